// File: rtl/id_ex_pipe_reg.sv
// Decode->execute pipeline register: latches the control word and operands, inserts load-use
// bubbles, applies jump flushes and execute stalls, and keeps saturating debug counters.
`timescale 1ns/1ps
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic              id_wmemE,
  input  logic              id_rmemE,
  input  logic              id_wregE,
  input  logic              id_CondEn,
  input  logic              id_jmpSel,
  input  logic              id_VF,
  input  logic [1:0]        id_jmpF,
  input  logic [2:0]        id_ALUins,
  input  logic [1:0]        id_ExtndSel,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_opA,
  input  logic [DATA_W-1:0] id_opB,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              ex_flush_i,
  input  logic              ex_stall_i,
  output logic              ex_wmemE_o,
  output logic              ex_rmemE_o,
  output logic              ex_wregE_o,
  output logic              ex_CondEn_o,
  output logic              ex_jmpSel_o,
  output logic              ex_VF_o,
  output logic [1:0]        ex_jmpF_o,
  output logic [2:0]        ex_ALUins_o,
  output logic [1:0]        ex_ExtndSel_o,
  output logic [REG_W-1:0]  ex_rs1_o,
  output logic [REG_W-1:0]  ex_rs2_o,
  output logic [REG_W-1:0]  ex_rd_o,
  output logic [DATA_W-1:0] ex_opA_o,
  output logic [DATA_W-1:0] ex_opB_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic              ex_valid_o,
  output logic              id_stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef struct packed {
    logic              wmem;
    logic              rmem;
    logic              wreg;
    logic              cond_en;
    logic              jmp_sel;
    logic              vf;
    logic [1:0]        jmp_f;
    logic [2:0]        alu_ins;
    logic [1:0]        extnd_sel;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm;
  } ex_word_t;

  ex_word_t         id_word_c;
  ex_word_t         ex_d, ex_q;
  logic             ex_valid_d, ex_valid_q;
  logic             hz_c;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    id_word_c = '{wmem: id_wmemE, rmem: id_rmemE, wreg: id_wregE, cond_en: id_CondEn,
                  jmp_sel: id_jmpSel, vf: id_VF, jmp_f: id_jmpF, alu_ins: id_ALUins,
                  extnd_sel: id_ExtndSel, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                  op_a: id_opA, op_b: id_opB, imm: id_imm};
  end

  // Flush beats stall beats load-use hazard beats normal capture.
  always_comb begin
    hz_c = id_valid_i & ex_valid_q & ex_q.rmem & ex_q.wreg &
           ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));
    ex_d        = ex_q;
    ex_valid_d  = ex_valid_q;
    id_stall_o  = 1'b0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (ex_flush_i) begin
      ex_d       = '0;
      ex_valid_d = 1'b0;
    end else if (ex_stall_i) begin
      id_stall_o = 1'b1;
    end else if (hz_c) begin
      ex_d       = '0;
      ex_valid_d = 1'b0;
      id_stall_o = 1'b1;
    end else begin
      ex_d       = id_valid_i ? id_word_c : '0;
      ex_valid_d = id_valid_i;
    end

    if (id_stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ex_flush_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= '0;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_wmemE_o    = ex_q.wmem;
  assign ex_rmemE_o    = ex_q.rmem;
  assign ex_wregE_o    = ex_q.wreg;
  assign ex_CondEn_o   = ex_q.cond_en;
  assign ex_jmpSel_o   = ex_q.jmp_sel;
  assign ex_VF_o       = ex_q.vf;
  assign ex_jmpF_o     = ex_q.jmp_f;
  assign ex_ALUins_o   = ex_q.alu_ins;
  assign ex_ExtndSel_o = ex_q.extnd_sel;
  assign ex_rs1_o      = ex_q.rs1;
  assign ex_rs2_o      = ex_q.rs2;
  assign ex_rd_o       = ex_q.rd;
  assign ex_opA_o      = ex_q.op_a;
  assign ex_opB_o      = ex_q.op_b;
  assign ex_imm_o      = ex_q.imm;
  assign ex_valid_o    = ex_valid_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: the driver pushes the hand-derived expectation for each
// cycle, a monitor pops it and compares the combinational stall and the registered EX state.
`timescale 1ns/1ps
module tb_id_ex_pipe_reg;

  localparam int K_CAP  = 0;
  localparam int K_BUB  = 1;
  localparam int K_HOLD = 2;
  localparam int K_RST  = 3;

  // {wmem, rmem, wreg, CondEn, jmpSel, VF, jmpF[1:0], ALUins[2:0], ExtndSel[1:0]}
  localparam logic [12:0] C_ALL1 = 13'h1FFF;
  localparam logic [12:0] C_PT   = 13'b0_0_1_1_0_0_00_101_00;
  localparam logic [12:0] C_LD   = 13'b0_1_1_0_0_0_00_000_01;
  localparam logic [12:0] C_ADD  = 13'b0_0_1_0_0_0_00_001_00;
  localparam logic [12:0] C_ST   = 13'b1_0_0_0_0_0_00_000_10;
  localparam logic [12:0] C_JMP  = 13'b0_0_0_0_1_1_01_010_00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid_i = 1'b0;
  logic [12:0] cur_ctrl = '0;
  logic [3:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [31:0] id_opA = '0, id_opB = '0, id_imm = '0;
  logic        ex_flush_i = 1'b0, ex_stall_i = 1'b0;

  logic        ex_wmemE_o, ex_rmemE_o, ex_wregE_o, ex_CondEn_o, ex_jmpSel_o, ex_VF_o;
  logic [1:0]  ex_jmpF_o, ex_ExtndSel_o;
  logic [2:0]  ex_ALUins_o;
  logic [3:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [31:0] ex_opA_o, ex_opB_o, ex_imm_o;
  logic        ex_valid_o, id_stall_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  id_ex_pipe_reg #(.DATA_W(32), .REG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i),
    .id_wmemE(cur_ctrl[12]), .id_rmemE(cur_ctrl[11]), .id_wregE(cur_ctrl[10]),
    .id_CondEn(cur_ctrl[9]), .id_jmpSel(cur_ctrl[8]), .id_VF(cur_ctrl[7]),
    .id_jmpF(cur_ctrl[6:5]), .id_ALUins(cur_ctrl[4:2]), .id_ExtndSel(cur_ctrl[1:0]),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_opA(id_opA), .id_opB(id_opB), .id_imm(id_imm),
    .ex_flush_i(ex_flush_i), .ex_stall_i(ex_stall_i),
    .ex_wmemE_o(ex_wmemE_o), .ex_rmemE_o(ex_rmemE_o), .ex_wregE_o(ex_wregE_o),
    .ex_CondEn_o(ex_CondEn_o), .ex_jmpSel_o(ex_jmpSel_o), .ex_VF_o(ex_VF_o),
    .ex_jmpF_o(ex_jmpF_o), .ex_ALUins_o(ex_ALUins_o), .ex_ExtndSel_o(ex_ExtndSel_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_opA_o(ex_opA_o), .ex_opB_o(ex_opB_o), .ex_imm_o(ex_imm_o),
    .ex_valid_o(ex_valid_o), .id_stall_o(id_stall_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_st;
    bit          st;
    logic [12:0] ctrl;
    logic [11:0] regs;
    logic [95:0] data;
    logic        valid;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  logic [12:0] e_ctrl = '0;
  logic [11:0] e_regs = '0;
  logic [95:0] e_data = '0;
  logic        e_valid = 1'b0;
  logic [15:0] e_sc = '0, e_fc = '0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: stall is checked mid-cycle, EX state just after the following edge.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        r = sb_q.pop_front();
        if (r.chk_st) chk("id_stall", 96'(id_stall_o), 96'(r.st));
        @(posedge clk);
        #1;
        chk("ctrl", 96'({ex_wmemE_o, ex_rmemE_o, ex_wregE_o, ex_CondEn_o, ex_jmpSel_o, ex_VF_o,
                         ex_jmpF_o, ex_ALUins_o, ex_ExtndSel_o}), 96'(r.ctrl));
        chk("regs", 96'({ex_rs1_o, ex_rs2_o, ex_rd_o}), 96'(r.regs));
        chk("data", {ex_opA_o, ex_opB_o, ex_imm_o}, r.data);
        chk("valid", 96'(ex_valid_o), 96'(r.valid));
        chk("stall_cnt", 96'(stall_cnt_o), 96'(r.sc));
        chk("flush_cnt", 96'(flush_cnt_o), 96'(r.fc));
        if (!ex_valid_o)
          chk("enables_idle", 96'({ex_wmemE_o, ex_rmemE_o, ex_wregE_o, ex_CondEn_o, ex_jmpSel_o}), 96'(0));
      end
    end
  end

  task automatic instr(input logic v, input logic [12:0] c, input logic [3:0] rs1, rs2, rd,
                       input logic u1, u2, input logic [31:0] a, b, im);
    id_valid_i = v; cur_ctrl = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_opA = a; id_opB = b; id_imm = im;
  endtask

  task automatic step(input bit rst, fl, st, input int kind, input bit exp_st, chk_st);
    exp_t r;
    rst_n = rst ? 1'b0 : 1'b1;
    ex_flush_i = fl;
    ex_stall_i = st;
    case (kind)
      K_CAP: begin
        e_valid = id_valid_i;
        e_ctrl  = id_valid_i ? cur_ctrl : '0;
        e_regs  = id_valid_i ? {id_rs1, id_rs2, id_rd} : '0;
        e_data  = id_valid_i ? {id_opA, id_opB, id_imm} : '0;
      end
      K_HOLD: ;
      default: begin
        e_valid = 1'b0; e_ctrl = '0; e_regs = '0; e_data = '0;
      end
    endcase
    if (kind == K_RST) begin
      e_sc = '0;
      e_fc = '0;
    end else begin
      if (exp_st && e_sc != 16'hFFFF) e_sc++;
      if (fl && e_fc != 16'hFFFF) e_fc++;
    end
    r.chk_st = chk_st; r.st = exp_st; r.ctrl = e_ctrl; r.regs = e_regs; r.data = e_data;
    r.valid = e_valid; r.sc = e_sc; r.fc = e_fc;
    sb_q.push_back(r);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #2;
    // Reset with every control bit high
    instr(1, C_ALL1, 4'hF, 4'hF, 4'hF, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(1, 0, 0, K_RST, 0, 0);
    step(1, 0, 0, K_RST, 0, 1);
    // Pass-through
    instr(1, C_PT, 4'h1, 4'h2, 4'h5, 1, 1, 32'hA5A5_0001, 32'h0000_1234, 32'hFFFF_FFF0);
    step(0, 0, 0, K_CAP, 0, 1);
    // Load-use on rs1: one bubble, then the add
    instr(1, C_LD, 4'h1, 4'h0, 4'h3, 1, 0, 32'h0000_0100, 32'h0, 32'h0000_0008);
    step(0, 0, 0, K_CAP, 0, 1);
    instr(1, C_ADD, 4'h3, 4'h2, 4'h7, 1, 1, 32'h1111_1111, 32'h2222_2222, 32'h0);
    step(0, 0, 0, K_BUB, 1, 1);
    step(0, 0, 0, K_CAP, 0, 1);
    // No false hazard: rs1 matches but unused
    instr(1, C_LD, 4'h1, 4'h0, 4'h3, 1, 0, 32'h0000_0200, 32'h0, 32'h0000_0004);
    step(0, 0, 0, K_CAP, 0, 1);
    instr(1, C_ADD, 4'h3, 4'h7, 4'h8, 0, 1, 32'h3333_3333, 32'h4444_4444, 32'h0);
    step(0, 0, 0, K_CAP, 0, 1);
    // No false hazard: different register
    instr(1, C_LD, 4'h1, 4'h0, 4'h3, 1, 0, 32'h0000_0300, 32'h0, 32'h0000_000C);
    step(0, 0, 0, K_CAP, 0, 1);
    instr(1, C_ADD, 4'h4, 4'h5, 4'h9, 1, 1, 32'h5555_5555, 32'h6666_6666, 32'h0);
    step(0, 0, 0, K_CAP, 0, 1);
    // Load-use on rs2
    instr(1, C_LD, 4'h2, 4'h0, 4'h9, 1, 0, 32'h0000_0400, 32'h0, 32'h0000_0010);
    step(0, 0, 0, K_CAP, 0, 1);
    instr(1, C_ST, 4'h1, 4'h9, 4'h0, 1, 1, 32'h7777_7777, 32'h8888_8888, 32'h0000_0020);
    step(0, 0, 0, K_BUB, 1, 1);
    step(0, 0, 0, K_CAP, 0, 1);
    // Invalid decode slot never hazards and captures as all-zero
    instr(1, C_LD, 4'h1, 4'h0, 4'h2, 1, 0, 32'h0000_0500, 32'h0, 32'h0000_0014);
    step(0, 0, 0, K_CAP, 0, 1);
    instr(0, C_ALL1, 4'h2, 4'h2, 4'hE, 1, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678);
    step(0, 0, 0, K_CAP, 0, 1);
    // Execute stall holds EX and stalls ID
    instr(1, C_JMP, 4'hA, 4'hB, 4'hC, 1, 0, 32'h0BAD_0001, 32'h0BAD_0002, 32'h0000_0040);
    step(0, 0, 0, K_CAP, 0, 1);
    instr(1, C_PT, 4'h6, 4'h7, 4'h8, 1, 1, 32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C);
    step(0, 0, 1, K_HOLD, 1, 1);
    step(0, 0, 0, K_CAP, 0, 1);
    // Flush and stall together: bubble, no ID stall
    instr(1, C_ADD, 4'h1, 4'h1, 4'h1, 1, 1, 32'h0000_0011, 32'h0000_0022, 32'h0);
    step(0, 1, 1, K_BUB, 0, 1);
    // Flush beats a load-use hazard
    instr(1, C_LD, 4'h1, 4'h0, 4'h6, 1, 0, 32'h0000_0600, 32'h0, 32'h0000_0018);
    step(0, 0, 0, K_CAP, 0, 1);
    instr(1, C_ADD, 4'h6, 4'h0, 4'h2, 1, 0, 32'h0000_0033, 32'h0, 32'h0);
    step(0, 1, 0, K_BUB, 0, 1);
    // Long stall saturates the stall counter while EX stays frozen
    instr(1, C_JMP, 4'h3, 4'h4, 4'h5, 0, 0, 32'hFACE_0001, 32'hFACE_0002, 32'hFACE_0003);
    step(0, 0, 0, K_CAP, 0, 1);
    instr(1, C_PT, 4'h1, 4'h2, 4'h3, 0, 0, 32'h1357_9BDF, 32'h2468_ACE0, 32'h0F0F_F0F0);
    for (int i = 0; i < 70000; i++) step(0, 0, 1, K_HOLD, 1, 1);
    // Reset mid-stall and mid-flush clears everything
    step(1, 1, 1, K_RST, 0, 0);
    step(0, 0, 0, K_CAP, 0, 1);
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 96'(sb_q.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
